uart_bus_master: RTL and testbench
==================================

Name: uart_bus_master

Overview:
Serial-driven bus initiator for debug and program loading. It decodes a byte-command stream from the UART receive side and issues word reads and writes on the same 30-bit word-address memory bus the core drives. It returns read data and acks through the UART transmit side. It sits beside the core, and an external arbiter uses its `active` output to grant it the bus.

Parameters:
READ_LATENCY, 1, cycles from the readenable pulse to the cycle in which readdata is sampled (1..7)
TIMEOUT, 1000000, maximum clk cycles allowed between bytes of one command before it is abandoned

Ports:
clk  input  1  system clock, all state on posedge
reset_n  input  1  asynchronous, active-low reset
rx_q  input  8  received byte
rx_valid  input  1  one-cycle strobe, rx_q valid
tx_data  output  8  byte to transmit
tx_valid  output  1  transmit request, held until accepted
tx_busy  input  1  transmitter busy; a byte is accepted on an edge where tx_valid=1 and tx_busy=0
address  output  30  bus word address (byte address bits [31:2])
writeenable  output  1  one-cycle write strobe
writedata  output  32  write data
byteena  output  4  byte enables, always 4'hF when writeenable=1
readenable  output  1  one-cycle read strobe
readdata  input  32  bus read data
active  output  1  command in progress (any state other than IDLE)

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE. All outputs are 0: tx_data, tx_valid, address, writeenable, writedata, byteena, readenable, active. The byte counter and timeout counter are also 0.
- Command protocol. All multi-byte fields are big-endian, most significant byte first.
  - 0x57 'W' + 4 address bytes + 4 data bytes: one bus write, then tx 0x4B 'K'.
  - 0x52 'R' + 4 address bytes: one bus read, then tx 4 data bytes, MSB first.
  - In IDLE, any other byte is silently ignored.
- Address: the 32-bit byte address is assembled and address<=addr[31:2]. Bits [1:0] are discarded with no alignment error.
- States: IDLE, ADDR, DATA, WRITE, READ, WAIT, RESP, ACK.
  - IDLE: rx_valid with 'W'/'R' -> ADDR; the byte counter is cleared and the command is latched.
  - ADDR: four rx_valid bytes are shifted in. After the 4th: 'W' -> DATA, 'R' -> READ.
  - DATA: four bytes are shifted into writedata. After the 4th -> WRITE.
  - WRITE: for exactly one cycle, writeenable=1, byteena=4'hF, with address and writedata stable. Next state is ACK.
  - READ: readenable=1 for exactly one cycle. Next state is WAIT.
  - WAIT: counts READ_LATENCY cycles after the READ cycle. readdata is captured on the final cycle into a 32-bit shift register. Next state is RESP.
  - RESP: tx_data=shift[31:24] with tx_valid=1. On acceptance, shift<<=8. After the 4th acceptance, tx_valid=0 and state goes to IDLE.
  - ACK: tx_data=0x4B with tx_valid=1. On acceptance, tx_valid=0 and state goes to IDLE.
- tx_valid and tx_data must not change while tx_valid=1 and the byte has not been accepted.
- At most one bus strobe is active in any cycle. writeenable and readenable are never both high.
- address and writedata hold their last values after a transaction.
- Timeout: a counter runs in ADDR and DATA and clears on each rx_valid. When it reaches TIMEOUT: state -> IDLE, partial fields are discarded, and no bus access occurs. The counter is inactive in other states.
- rx_valid arriving in WRITE, READ, WAIT, RESP or ACK is dropped. It is not queued and is not interpreted as a new command.
- rx_valid in the same cycle the timeout fires: the timeout wins and the byte is dropped.
- Reset mid-operation: any pending strobe and tx_valid drop immediately on reset_n assertion. No partial command survives.
- Back-to-back commands: a command byte arriving in the cycle after return to IDLE is accepted normally.

Test Plan:
- Write: send 57 00 00 01 08 DE AD BE EF -> one writeenable pulse with address=30'h42, writedata=32'hDEADBEEF, byteena=4'hF; then tx 0x4B exactly once.
- Read: send 52 80 00 00 04; the bus returns readdata=32'h12345678 at READ_LATENCY=1 -> one readenable pulse with address=30'h20000001; tx bytes 12 34 56 78 in order.
- tx backpressure: hold tx_busy=1 for 50 cycles during RESP -> tx_valid stays 1 and tx_data stays 0x12 with no byte lost or duplicated. After release, all 4 bytes are delivered.
- Garbage and timeout: send 0x00 0xFF, then 57 01 02 and stall longer than TIMEOUT (set to 100). Expect no bus strobe, active returns to 0, and a subsequent full write command works.
- Dropped rx: inject an rx byte 0x52 during WAIT -> it is ignored; only one read occurs and only 4 response bytes are sent.
- Reset: assert reset_n=0 during WRITE or RESP -> all outputs become 0 asynchronously, and state is IDLE after release.

Source files
------------

// File: rtl/uart_bus_master_if.sv
// Bus-side signal bundle of the UART-driven bus initiator: byte streams in/out
// plus the 30-bit word-address memory bus shared with the core.
interface uart_bus_master_if;
    logic [7:0]  rx_q;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_busy;
    logic [29:0] address;
    logic        writeenable;
    logic [31:0] writedata;
    logic [3:0]  byteena;
    logic        readenable;
    logic [31:0] readdata;
    logic        active;

    modport master (
        input  rx_q, rx_valid, tx_busy, readdata,
        output tx_data, tx_valid, address, writeenable, writedata, byteena,
               readenable, active
    );

    modport slave (
        output rx_q, rx_valid, tx_busy, readdata,
        input  tx_data, tx_valid, address, writeenable, writedata, byteena,
               readenable, active
    );
endinterface

// File: rtl/uart_bus_master.sv
// Decodes 'W'/'R' byte commands from the UART and issues single-word bus
// writes/reads, answering with 'K' or the four read-data bytes.
module uart_bus_master #(
    parameter int READ_LATENCY = 1,
    parameter int TIMEOUT      = 1000000
) (
    input  logic              clk,
    input  logic              reset_n,
    uart_bus_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, ADDR, DATA, WRITE, READ, WAIT, RESP, ACK} state_t;

    localparam int STAGES = READ_LATENCY - 1;
    localparam int TW     = $clog2(TIMEOUT + 1);

    state_t      state, state_nxt;
    logic        cmd_w;
    logic [1:0]  byte_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [29:0] addr_sh;
    logic [31:0] shift;
    logic [STAGES:0] vld_pipe;
    logic [29:0] address_q;
    logic [31:0] writedata_q;
    logic        cmd_hit, tmo_hit, accept;

    assign cmd_hit = bus.rx_valid && (bus.rx_q == 8'h57 || bus.rx_q == 8'h52);
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));

    // Outputs decode straight from state so an async reset clears them at once.
    assign bus.tx_valid    = (state == RESP) || (state == ACK);
    assign bus.tx_data     = (state == RESP) ? shift[31:24] :
                             (state == ACK)  ? 8'h4B : 8'h00;
    assign bus.writeenable = (state == WRITE);
    assign bus.byteena     = {4{state == WRITE}};
    assign bus.readenable  = (state == READ);
    assign bus.active      = (state != IDLE);
    assign bus.address     = address_q;
    assign bus.writedata   = writedata_q;
    assign accept          = bus.tx_valid && !bus.tx_busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (cmd_hit) state_nxt = ADDR;
            ADDR: begin
                if (tmo_hit)                               state_nxt = IDLE;
                else if (bus.rx_valid && byte_cnt == 2'd3) state_nxt = cmd_w ? DATA : READ;
            end
            DATA: begin
                if (tmo_hit)                               state_nxt = IDLE;
                else if (bus.rx_valid && byte_cnt == 2'd3) state_nxt = WRITE;
            end
            WRITE: state_nxt = ACK;
            READ:  state_nxt = WAIT;
            WAIT:  if (vld_pipe[STAGES]) state_nxt = RESP;
            RESP:  if (accept && byte_cnt == 2'd3) state_nxt = IDLE;
            ACK:   if (accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address/data are only published to the bus once a command is complete,
    // so an abandoned command leaves the previous values in place.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_w       <= 1'b0;
            byte_cnt    <= '0;
            tmo_cnt     <= '0;
            addr_sh     <= '0;
            shift       <= '0;
            vld_pipe    <= '0;
            address_q   <= '0;
            writedata_q <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_hit) begin
                    cmd_w    <= (bus.rx_q == 8'h57);
                    byte_cnt <= '0;
                    tmo_cnt  <= '0;
                end
                ADDR, DATA: begin
                    if (tmo_hit) begin
                        tmo_cnt <= '0;
                    end else if (bus.rx_valid) begin
                        tmo_cnt  <= '0;
                        byte_cnt <= byte_cnt + 1'b1;
                        if (state == ADDR) begin
                            if (byte_cnt == 2'd3) begin
                                addr_sh <= {addr_sh[23:0], bus.rx_q[7:2]};
                                if (!cmd_w) address_q <= {addr_sh[23:0], bus.rx_q[7:2]};
                            end else begin
                                addr_sh <= {addr_sh[21:0], bus.rx_q};
                            end
                        end else begin
                            shift <= {shift[23:0], bus.rx_q};
                            if (byte_cnt == 2'd3) begin
                                address_q   <= addr_sh;
                                writedata_q <= {shift[23:0], bus.rx_q};
                            end
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                READ: begin
                    vld_pipe    <= '0;
                    vld_pipe[0] <= 1'b1;
                end
                WAIT: begin
                    vld_pipe <= vld_pipe << 1;
                    if (vld_pipe[STAGES]) begin
                        shift    <= bus.readdata;
                        byte_cnt <= '0;
                    end
                end
                RESP: if (accept) begin
                    shift    <= {shift[23:0], 8'h00};
                    byte_cnt <= byte_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_bus_master.sv
// Randomized bench for uart_bus_master against a command-level model with a
// memory map, expected bus-op queues and an expected tx byte stream.
module tb_uart_bus_master;
    localparam int LAT = 1;
    localparam int TMO = 100;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    uart_bus_master_if bus();

    uart_bus_master #(.READ_LATENCY(LAT), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.master)
    );

    int vectors = 0, miscompares = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference state: memory image plus what the bus and tx side must show next.
    logic [31:0] mem [logic [29:0]];
    logic [61:0] exp_wr[$];
    logic [29:0] exp_rd[$];
    logic [7:0]  exp_tx[$];
    logic [31:0] waddrs[$];
    int we_cnt = 0, re_cnt = 0, tx_cnt = 0;
    int busy_hold = 0, busy_pct = 0;
    logic [7:0]  re_hist = '0;
    logic        prev_pend = 1'b0;
    logic [7:0]  prev_data = '0;
    logic [61:0] e_wr;
    logic [29:0] e_rd;

    function automatic logic [127:0] outs();
        return {50'd0, bus.tx_data, bus.tx_valid, bus.address, bus.writeenable,
                bus.writedata, bus.byteena, bus.readenable, bus.active};
    endfunction

    initial begin
        bus.rx_q = '0; bus.rx_valid = 1'b0; bus.tx_busy = 1'b0; bus.readdata = '0;
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_pend = 1'b0;
            re_hist   = '0;
        end else begin
            if (bus.writeenable) begin
                we_cnt++;
                chk("strobe_excl", {127'd0, bus.readenable}, 128'd0);
                chk("byteena", {124'd0, bus.byteena}, 128'hF);
                if (exp_wr.size() == 0) chk("wr_unexpected", 128'd1, 128'd0);
                else begin
                    e_wr = exp_wr.pop_front();
                    chk("wr_addr_data", {66'd0, bus.address, bus.writedata}, {66'd0, e_wr});
                end
            end
            if (bus.readenable) begin
                re_cnt++;
                if (exp_rd.size() == 0) chk("rd_unexpected", 128'd1, 128'd0);
                else begin
                    e_rd = exp_rd.pop_front();
                    chk("rd_addr", {98'd0, bus.address}, {98'd0, e_rd});
                end
            end
            if (prev_pend)
                chk("tx_hold", {119'd0, bus.tx_valid, bus.tx_data}, {119'd0, 1'b1, prev_data});
            // Bus slave: data is only valid in the cycle LAT after the read strobe.
            re_hist = {re_hist[6:0], bus.readenable};
            if (re_hist[LAT]) bus.readdata = mem.exists(bus.address) ? mem[bus.address] : 32'hBAD0BAD0;
            else              bus.readdata = $urandom;
            if (busy_hold > 0) begin busy_hold--; bus.tx_busy = 1'b1; end
            else bus.tx_busy = ($urandom_range(99) < busy_pct);
            if (bus.tx_valid && !bus.tx_busy) begin
                tx_cnt++;
                if (exp_tx.size() == 0) chk("tx_unexpected", {120'd0, bus.tx_data}, 128'h1FF);
                else chk("tx_byte", {120'd0, bus.tx_data}, {120'd0, exp_tx.pop_front()});
                prev_pend = 1'b0;
            end else begin
                prev_pend = bus.tx_valid;
            end
            prev_data = bus.tx_data;
        end
    end

    task automatic pulse(input logic [7:0] b);
        bus.rx_q = b; bus.rx_valid = 1'b1;
        @(negedge clk) bus.rx_valid = 1'b0;
    endtask

    // gap < 0: drive in the current cycle (back-to-back after idle).
    task automatic send(input logic [7:0] b, input int gap);
        if (gap >= 0) begin
            repeat (gap) @(negedge clk);
            @(negedge clk);
        end
        pulse(b);
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int i = 3; i >= 0; i--) send(w[8*i +: 8], int'($urandom_range(maxgap)));
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int maxgap, input bit bb);
        exp_wr.push_back({a[31:2], d});
        exp_tx.push_back(8'h4B);
        mem[a[31:2]] = d;
        send(8'h57, bb ? -1 : int'($urandom_range(maxgap)));
        send_word(a, maxgap);
        send_word(d, maxgap);
    endtask

    // inject: 0 none, 1 'R' during WAIT, 2 'W' during RESP.
    task automatic do_read(input logic [31:0] a, input int maxgap, input bit bb, input int inject);
        logic [29:0] w;
        logic [31:0] d;
        int n;
        w = a[31:2];
        if (!mem.exists(w)) mem[w] = $urandom;
        d = mem[w];
        exp_rd.push_back(w);
        for (int i = 3; i >= 0; i--) exp_tx.push_back(d[8*i +: 8]);
        send(8'h52, bb ? -1 : int'($urandom_range(maxgap)));
        send_word(a, maxgap);
        if (inject == 1) begin
            n = 0;
            while (!bus.readenable && n < 20) begin @(negedge clk); n++; end
            chk("inj_rd_strobe", {127'd0, bus.readenable}, 128'd1);
            @(negedge clk) pulse(8'h52);
        end else if (inject == 2) begin
            n = 0;
            while (!bus.tx_valid && n < 50) begin @(negedge clk); n++; end
            chk("inj_resp_seen", {127'd0, bus.tx_valid}, 128'd1);
            pulse(8'h57);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((bus.active || exp_tx.size() != 0) && n < 5000) begin @(negedge clk); n++; end
        chk({tag, "_timeout"}, {127'd0, n < 5000}, 128'd1);
        chk({tag, "_queues"}, 128'(exp_wr.size() + exp_rd.size() + exp_tx.size()), 128'd0);
    endtask

    task automatic flush();
        exp_wr.delete(); exp_rd.delete(); exp_tx.delete();
    endtask

    initial begin
        logic [31:0] a, d;
        int w0, r0, t0, n;

        #1 reset_n = 1'b0;
        #1 chk("reset_outs", outs(), 128'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset_idle", outs(), 128'd0);

        // Directed write: byte address 0x108 -> word 0x42.
        do_write(32'h0000_0108, 32'hDEAD_BEEF, 0, 1'b0);
        wait_idle("dir_wr");
        chk("wr_held", {66'd0, bus.address, bus.writedata}, {66'd0, 30'h42, 32'hDEAD_BEEF});

        // Directed read with 50-cycle tx backpressure on the first byte.
        mem[30'h2000_0001] = 32'h1234_5678;
        t0 = tx_cnt;
        do_read(32'h8000_0004, 0, 1'b0, 0);
        busy_hold = 55;
        repeat (30) @(negedge clk);
        chk("bp_hold", {119'd0, bus.tx_valid, bus.tx_data}, {119'd0, 1'b1, 8'h12});
        wait_idle("dir_rd");
        chk("bp_tx_count", 128'(tx_cnt - t0), 128'd4);

        // Garbage bytes, then an abandoned write that must time out silently.
        w0 = we_cnt; r0 = re_cnt;
        send(8'h00, 0); send(8'hFF, 2);
        send(8'h57, 1); send(8'h01, 1); send(8'h02, 1);
        repeat (TMO + 50) @(negedge clk);
        chk("tmo_idle", {127'd0, bus.active}, 128'd0);
        chk("tmo_no_strobe", 128'(we_cnt - w0 + re_cnt - r0), 128'd0);
        chk("tmo_addr_kept", {98'd0, bus.address}, {98'd0, 30'h2000_0001});
        do_write(32'h0000_0040, 32'hCAFE_F00D, 2, 1'b0);
        wait_idle("post_tmo");

        // Inter-byte gaps close to the limit must not trip the timeout.
        busy_pct = 30;
        do_write($urandom, $urandom, TMO - 10, 1'b0);
        wait_idle("near_tmo");

        // Stray command bytes during WAIT and RESP are dropped.
        r0 = re_cnt; t0 = tx_cnt;
        do_read($urandom, 1, 1'b0, 1);
        wait_idle("drop_wait");
        do_read($urandom, 1, 1'b1, 2);
        wait_idle("drop_resp");
        repeat (5) @(negedge clk);
        chk("drop_rd_count", 128'(re_cnt - r0), 128'd2);
        chk("drop_tx_count", 128'(tx_cnt - t0), 128'd8);

        // Random traffic, back-to-back on alternate commands.
        for (int k = 0; k < 40; k++) begin
            busy_pct = $urandom_range(70);
            if ($urandom_range(1) == 1) begin
                a = $urandom; d = $urandom;
                waddrs.push_back(a);
                do_write(a, d, 4, k % 2 == 0);
            end else begin
                if (waddrs.size() > 0 && $urandom_range(1) == 1)
                    a = waddrs[$urandom_range(waddrs.size() - 1)];
                else a = $urandom;
                do_read(a, 4, k % 2 == 0, 0);
            end
            wait_idle("rand");
        end

        // Reset during RESP.
        busy_pct = 50;
        do_read(32'h0000_1000, 0, 1'b0, 0);
        n = 0;
        while (!bus.tx_valid && n < 50) begin @(negedge clk); n++; end
        chk("rst_resp_seen", {127'd0, bus.tx_valid}, 128'd1);
        #2 reset_n = 1'b0;
        #1 chk("rst_resp_outs", outs(), 128'd0);
        flush();
        @(negedge clk) reset_n = 1'b1;
        @(negedge clk) chk("rst_resp_idle", outs(), 128'd0);

        // Reset during WRITE.
        busy_pct = 0;
        do_write(32'h0000_2000, 32'h5555_AAAA, 0, 1'b0);
        chk("rst_wr_seen", {127'd0, bus.writeenable}, 128'd1);
        #2 reset_n = 1'b0;
        #1 chk("rst_wr_outs", outs(), 128'd0);
        flush();
        @(negedge clk) reset_n = 1'b1;
        @(negedge clk) chk("rst_wr_idle", {127'd0, bus.active}, 128'd0);

        // Fully functional after reset.
        do_write(32'h0000_3004, 32'h0BAD_CAFE, 1, 1'b0);
        wait_idle("post_rst_wr");
        do_read(32'h0000_3004, 1, 1'b1, 0);
        wait_idle("post_rst_rd");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
